// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: unified op codes,
// FSM state encoding and small decode helpers for the M-extension ops.
package exe_pkg;

    localparam int OP_W = 5;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_md(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Returns {op1 signed, op2 signed}; MUL is unsigned since its low half is sign-agnostic.
    function automatic logic [1:0] md_signed(input logic [4:0] op);
        logic [1:0] s;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 2'b11;
            OP_MULHSU:               s = 2'b10;
            default:                 s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) on operand
// magnitudes, one step per cycle over XLEN cycles.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   b_q;
    logic              div_q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, b_q};
        acc_next = {sum, acc[XLEN-1:1]};
        if (div_q) begin
            acc_next = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]),
                        acc[XLEN-2:0], ~diff[XLEN]};
        end
    end

    assign done   = (cnt == CW'(1));
    assign result = (cnt != '0) ? acc_next : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            acc   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (kill) begin
            cnt <= '0;
        end else if (start) begin
            cnt   <= CW'(XLEN);
            acc   <= {{XLEN{1'b0}}, a};
            b_q   <= b;
            div_q <= is_div;
        end else if (cnt != '0) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU and M-extension fast paths,
// iterative multiply/divide, valid/ready handshakes and a registered result.
module exe_stage_mc #(
    parameter int XLEN   = 64,
    parameter int OP_W   = 5,
    parameter int TYPE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic [TYPE_W-1:0] inst_type_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   rd_data,
    output logic [TYPE_W-1:0] inst_type_o,
    output logic              busy
);

    import exe_pkg::*;

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [4:0]        opc;
    logic [SH_W-1:0]   shamt;
    logic              xfer, md_op, is_div_op, dz, ovf, fast, start, mdu_done;
    logic [1:0]        sgn;
    logic [XLEN-1:0]   alu_res, fast_res, single_res, a_mag, b_mag, md_res, quo, rem;
    logic [2*XLEN-1:0] raw, prod;
    logic [2:0]        md_sel;
    logic              neg_q, rem_neg_q;
    logic [TYPE_W-1:0] tag_q;

    assign opc       = 5'(op);
    assign shamt     = op2[SH_W-1:0];
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign xfer      = in_valid && in_ready && !flush;
    assign busy      = (state == ST_CALC);
    assign md_op     = is_md(opc);
    assign is_div_op = opc[2];
    assign sgn       = md_signed(opc);
    assign dz        = (op2 == '0);
    assign ovf       = sgn[0] && (op1 == MIN_NEG) && (op2 == '1);
    assign fast      = md_op && is_div_op && (dz || ovf);
    assign start     = xfer && md_op && !fast;
    assign a_mag     = (sgn[1] && op1[XLEN-1]) ? -op1 : op1;
    assign b_mag     = (sgn[0] && op2[XLEN-1]) ? -op2 : op2;

    always_comb begin
        alu_res = '0;
        case (opc)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_SLL:  alu_res = op1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            OP_XOR:  alu_res = op1 ^ op2;
            OP_SRL:  alu_res = op1 >> shamt;
            OP_SRA:  alu_res = $signed(op1) >>> shamt;
            OP_OR:   alu_res = op1 | op2;
            OP_AND:  alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

    // Divide-by-zero takes precedence over the signed overflow case.
    assign fast_res   = opc[1] ? (dz ? op1 : '0) : (dz ? '1 : op1);
    assign single_res = fast ? fast_res : alu_res;

    assign prod = neg_q ? -raw : raw;
    assign quo  = raw[XLEN-1:0];
    assign rem  = raw[2*XLEN-1:XLEN];

    always_comb begin
        md_res = '0;
        case (md_sel)
            3'b000:                 md_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res = neg_q ? -quo : quo;
            default:                md_res = rem_neg_q ? -rem : rem;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (start),
        .is_div (is_div_op),
        .a      (a_mag),
        .b      (b_mag),
        .done   (mdu_done),
        .result (raw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            rd_data     <= '0;
            inst_type_o <= '0;
            md_sel      <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            tag_q       <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (xfer) begin
                        if (start) begin
                            state     <= ST_CALC;
                            md_sel    <= opc[2:0];
                            neg_q     <= (sgn[1] & op1[XLEN-1]) ^ (sgn[0] & op2[XLEN-1]);
                            rem_neg_q <= sgn[1] & op1[XLEN-1];
                            tag_q     <= inst_type_i;
                        end else begin
                            out_valid   <= 1'b1;
                            rd_data     <= single_res;
                            inst_type_o <= inst_type_i;
                        end
                    end
                end
                ST_CALC: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (mdu_done) begin
                        if (!out_valid || out_ready) begin
                            state       <= ST_IDLE;
                            out_valid   <= 1'b1;
                            rd_data     <= md_res;
                            inst_type_o <= tag_q;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid   <= 1'b1;
                        rd_data     <= md_res;
                        inst_type_o <= tag_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc with a reference-model scoreboard that
// checks every consumed result, plus hand-computed literal expectations.
module tb_exe_stage_mc;

    import exe_pkg::*;

    localparam int XLEN = 64;
    localparam int TW   = 5;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [4:0]      op = '0;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic [TW-1:0]   inst_type_i = '0;
    logic            in_ready, out_valid, busy;
    logic [XLEN-1:0] rd_data;
    logic [TW-1:0]   inst_type_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [TW-1:0]   tag;
    } exp_t;

    exp_t expq[$];
    exp_t e;

    always #5 clk = ~clk;

    exe_stage_mc #(.XLEN(XLEN), .OP_W(5), .TYPE_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .inst_type_i (inst_type_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd_data     (rd_data),
        .inst_type_o (inst_type_o),
        .busy        (busy)
    );

    // Architectural reference: RISC-V RV + M semantics with wide arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [4:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [2*XLEN-1:0] sa, sb, ua, ub, p;
        logic signed [XLEN-1:0]   qa, qb;
        int                       sh;
        sa = {{XLEN{a[XLEN-1]}}, a};
        sb = {{XLEN{b[XLEN-1]}}, b};
        ua = {{XLEN{1'b0}}, a};
        ub = {{XLEN{1'b0}}, b};
        qa = a;
        qb = b;
        sh = int'(b[5:0]);
        p  = '0;
        model = '0;
        case (o)
            OP_ADD:    model = a + b;
            OP_SUB:    model = a - b;
            OP_SLL:    model = a << sh;
            OP_SLT:    model = (qa < qb) ? XLEN'(1) : XLEN'(0);
            OP_SLTU:   model = (a < b) ? XLEN'(1) : XLEN'(0);
            OP_XOR:    model = a ^ b;
            OP_SRL:    model = a >> sh;
            OP_SRA:    model = qa >>> sh;
            OP_OR:     model = a | b;
            OP_AND:    model = a & b;
            OP_MUL:    begin p = ua * ub; model = p[XLEN-1:0]; end
            OP_MULH:   begin p = sa * sb; model = p[2*XLEN-1:XLEN]; end
            OP_MULHSU: begin p = sa * ub; model = p[2*XLEN-1:XLEN]; end
            OP_MULHU:  begin p = ua * ub; model = p[2*XLEN-1:XLEN]; end
            OP_DIV: begin
                if (b == '0) model = '1;
                else if (a == MINV && b == '1) model = a;
                else model = qa / qb;
            end
            OP_DIVU:   model = (b == '0) ? '1 : a / b;
            OP_REM: begin
                if (b == '0) model = a;
                else if (a == MINV && b == '1) model = '0;
                else model = qa % qb;
            end
            OP_REMU:   model = (b == '0) ? a : a % b;
            default:   model = '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] o, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TW-1:0] t);
        logic got;
        int   n;
        op = o; op1 = a; op2 = b; inst_type_i = t;
        in_valid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: op %0d not accepted after %0d cycles", o, n);
        end
    endtask

    task automatic waitOut(input int maxc, output int lat);
        lat = 0;
        while (!out_valid && lat < maxc) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL out_timeout: out_valid 0 after %0d cycles, expected 1", lat);
        end
    endtask

    // Scoreboard: every transfer pushes the model result, every consumed output pops it.
    always @(negedge clk) begin
        if (!rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_out: got %h with no pending op", rd_data);
                end else begin
                    e = expq.pop_front();
                    checkOutput("sb_data", rd_data, e.data);
                    checkOutput("sb_tag", XLEN'(inst_type_o), XLEN'(e.tag));
                end
            end
            if (flush) expq.delete();
            else if (in_valid && in_ready) expq.push_back({model(op, op1, op2), inst_type_i});
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [4:0]      o;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int nout;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", XLEN'(out_valid), '0);
        checkOutput("rst_rd_data", rd_data, '0);
        checkOutput("rst_tag", XLEN'(inst_type_o), '0);
        checkOutput("rst_busy", XLEN'(busy), '0);
        checkOutput("rst_in_ready", XLEN'(in_ready), XLEN'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("pin_model_mulhsu", model(OP_MULHSU, -64'sd3, 64'd5), '1);
        checkOutput("pin_model_rem", model(OP_REM, -64'sd7, 64'd2), '1);
        checkOutput("pin_model_div", model(OP_DIV, -64'sd7, 64'd2), -64'sd3);

        // Reset mid-CALC of DIV.
        applyStimulus(OP_DIV, 64'd100, 64'd7, 5'd3);
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("midcalc_busy", XLEN'(busy), XLEN'(1));
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", XLEN'(out_valid), '0);
        checkOutput("midrst_busy", XLEN'(busy), '0);
        checkOutput("midrst_in_ready", XLEN'(in_ready), XLEN'(1));
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        nout = 0;
        repeat (80) begin @(posedge clk); #1; if (out_valid) nout++; end
        checkOutput("midrst_no_stale", XLEN'(nout), '0);

        // Back-to-back ALU ops.
        applyStimulus(OP_ADD, 64'd5, -64'sd7, 5'd1);
        checkOutput("add_valid", XLEN'(out_valid), XLEN'(1));
        checkOutput("add_data", rd_data, -64'sd2);
        applyStimulus(OP_SLTU, 64'd1, 64'd2, 5'd2);
        checkOutput("sltu_valid", XLEN'(out_valid), XLEN'(1));
        checkOutput("sltu_data", rd_data, 64'd1);
        applyStimulus(OP_SRA, MINV, 64'd4, 5'd3);
        checkOutput("sra_valid", XLEN'(out_valid), XLEN'(1));
        checkOutput("sra_data", rd_data, 64'hF800_0000_0000_0000);
        checkOutput("sra_tag", XLEN'(inst_type_o), XLEN'(3));
        @(posedge clk);
        #1;
        checkOutput("alu_drained", XLEN'(out_valid), '0);

        // Iterative multiply latency and results.
        applyStimulus(OP_MULH, '1, '1, 5'd7);
        checkOutput("mulh_busy", XLEN'(busy), XLEN'(1));
        checkOutput("mulh_in_ready", XLEN'(in_ready), '0);
        waitOut(200, lat);
        checkOutput("mulh_latency", XLEN'(lat), XLEN'(XLEN));
        checkOutput("mulh_data", rd_data, '0);
        applyStimulus(OP_MUL, '1, '1, 5'd8);
        waitOut(200, lat);
        checkOutput("mul_data", rd_data, 64'd1);

        // Divide fast paths: one cycle each.
        applyStimulus(OP_DIV, 64'd7, 64'd0, 5'd9);
        checkOutput("div0_valid", XLEN'(out_valid), XLEN'(1));
        checkOutput("div0_data", rd_data, '1);
        applyStimulus(OP_REM, 64'd7, 64'd0, 5'd9);
        checkOutput("rem0_data", rd_data, 64'd7);
        applyStimulus(OP_DIV, MINV, '1, 5'd9);
        checkOutput("divovf_data", rd_data, MINV);
        applyStimulus(OP_REM, MINV, '1, 5'd9);
        checkOutput("removf_data", rd_data, '0);
        @(posedge clk);
        #1;

        // Back-pressure after DIVU completion.
        applyStimulus(OP_DIVU, 64'd100, 64'd7, 5'd10);
        out_ready = 1'b0;
        waitOut(200, lat);
        checkOutput("divu_latency", XLEN'(lat), XLEN'(XLEN));
        op = OP_ADD; op1 = 64'd3; op2 = 64'd4; inst_type_i = 5'd11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_data", rd_data, 64'd14);
            checkOutput("bp_valid", XLEN'(out_valid), XLEN'(1));
            checkOutput("bp_in_ready", XLEN'(in_ready), '0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", XLEN'(in_ready), XLEN'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_next_data", rd_data, 64'd7);
        checkOutput("bp_next_tag", XLEN'(inst_type_o), XLEN'(11));
        @(posedge clk);
        #1;

        // Flush in cycle 10 of REMU with a competing in_valid.
        applyStimulus(OP_REMU, 64'd100, 64'd7, 5'd12);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        op = OP_ADD; op1 = 64'd1; op2 = 64'd1; inst_type_i = 5'd13;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_busy", XLEN'(busy), '0);
        checkOutput("flush_in_ready", XLEN'(in_ready), XLEN'(1));
        checkOutput("flush_out_valid", XLEN'(out_valid), '0);
        nout = 0;
        repeat (80) begin @(posedge clk); #1; if (out_valid) nout++; end
        checkOutput("flush_no_result", XLEN'(nout), '0);

        // Mixed directed vectors checked by the scoreboard.
        vecs.push_back('{OP_SUB,    64'd3,                   64'd10});
        vecs.push_back('{OP_SLL,    64'h1,                   64'd67});
        vecs.push_back('{OP_SLT,    -64'sd1,                 64'd1});
        vecs.push_back('{OP_SRL,    MINV,                    64'd63});
        vecs.push_back('{OP_XOR,    64'hF0F0,                64'h0FF0});
        vecs.push_back('{OP_OR,     64'hF000,                64'h000F});
        vecs.push_back('{OP_AND,    64'hFF00,                64'h0FF0});
        vecs.push_back('{5'd12,     64'd9,                   64'd9});
        vecs.push_back('{OP_MULHSU, -64'sd3,                 64'd5});
        vecs.push_back('{OP_MULH,   MINV,                    MINV});
        vecs.push_back('{OP_MULHU,  '1,                      64'd2});
        vecs.push_back('{OP_DIV,    -64'sd7,                 64'd2});
        vecs.push_back('{OP_REM,    64'd7,                   -64'sd3});
        vecs.push_back('{OP_REMU,   64'hFFFF_FFFF_0000_0001, 64'd12345});
        vecs.push_back('{OP_DIVU,   '1,                      64'd3});
        foreach (vecs[i]) applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b, TW'(i));
        repeat (80) begin @(posedge clk); #1; end
        checkOutput("sb_drained", XLEN'(expq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
